// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Branch predictor and flush controller for the 5-stage RISC-V pipeline.
//   A PC-indexed table of CNT_W-bit saturating counters gives a taken/not-taken
//   prediction at fetch. Conditional branches, JAL and JALR are resolved at
//   execute, where the table is trained and pc_sel plus the IF/ID and ID/EX
//   flush controls are driven. A redirect flush can be stretched to
//   FLUSH_CYCLES cycles. Saturating statistics counters are kept for debug.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_pc, if_inst           fetch lookup (qualified by BRANCH opcode)
//   pred_taken               fetch prediction (counter MSB)
//   ex_valid, ex_pc, ex_inst execute-stage instruction
//   ex_pred, ex_taken        carried prediction and ALU outcome
//   stall                    load-use stall from the hazard unit
//   pc_sel                   0 = take corrected target, 1 = normal path
//   flush_ifid, flush_idex   pipeline register clears
//   stat_branches            resolved conditional branches (saturating)
//   stat_mispred             mispredicted conditional branches (saturating)
module branch_predict_unit #(
   parameter int ENTRIES      = 16,
   parameter int IDX_W        = 4,
   parameter int CNT_W        = 2,
   parameter int FLUSH_CYCLES = 1,
   parameter int STAT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       if_pc,
   input  logic [31:0]       if_inst,
   output logic              pred_taken,
   input  logic              ex_valid,
   input  logic [31:0]       ex_pc,
   input  logic [31:0]       ex_inst,
   input  logic              ex_pred,
   input  logic              ex_taken,
   input  logic              stall,
   output logic              pc_sel,
   output logic              flush_ifid,
   output logic              flush_idex,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispred
);

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // weakly not-taken: 2^(CNT_W-1)-1
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((2 ** (CNT_W - 1)) - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   localparam int HOLD_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(FLUSH_CYCLES - 1);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t            state;
   logic [HOLD_W-1:0] hold_cnt;
   logic [CNT_W-1:0]  pht [ENTRIES];

   logic [IDX_W-1:0]  if_idx, ex_idx;
   logic              ex_br, ex_jmp, mispred, redirect;

   assign if_idx = if_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];

   // Lookup reads the registered table, so a same-cycle update to the same
   // index is seen only on the following cycle.
   assign pred_taken = (if_inst[6:0] == OP_BRANCH) & pht[if_idx][CNT_W-1];

   assign ex_br    = ex_valid & (ex_inst[6:0] == OP_BRANCH);
   assign ex_jmp   = ex_valid & ((ex_inst[6:0] == OP_JAL) | (ex_inst[6:0] == OP_JALR));
   assign mispred  = ex_br & (ex_pred != ex_taken);
   assign redirect = ex_jmp | mispred;

   // Priority: reset, redirect, hold, stall, idle.
   always_comb begin
      pc_sel     = 1'b1;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      if (rst) begin
         flush_ifid = 1'b1;
         flush_idex = 1'b1;
      end else if (redirect) begin
         pc_sel     = 1'b0;
         flush_ifid = 1'b1;
         flush_idex = 1'b1;
      end else if (state == HOLD) begin
         flush_ifid = 1'b1;
         flush_idex = 1'b1;
      end else if (stall) begin
         // bubble into EX while IF/ID holds its instruction
         flush_idex = 1'b1;
      end
   end

   // Flush stretch: the redirect cycle is the first flush cycle, HOLD
   // covers the remaining FLUSH_CYCLES-1. A redirect in HOLD reloads.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         hold_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (redirect && FLUSH_CYCLES > 1) begin
                  state    <= HOLD;
                  hold_cnt <= HOLD_LOAD;
               end
            end
            HOLD: begin
               if (redirect) begin
                  hold_cnt <= HOLD_LOAD;
               end else if (hold_cnt <= HOLD_W'(1)) begin
                  state    <= IDLE;
                  hold_cnt <= '0;
               end else begin
                  hold_cnt <= hold_cnt - HOLD_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               hold_cnt <= '0;
            end
         endcase
      end
   end

   // Counter training on every valid conditional branch.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) pht[i] <= CNT_INIT;
      end else if (ex_br) begin
         if (ex_taken) begin
            if (pht[ex_idx] != CNT_MAX) pht[ex_idx] <= pht[ex_idx] + CNT_W'(1);
         end else begin
            if (pht[ex_idx] != '0) pht[ex_idx] <= pht[ex_idx] - CNT_W'(1);
         end
      end
   end

   // Statistics saturate at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branches <= '0;
         stat_mispred  <= '0;
      end else begin
         if (ex_br && stat_branches != '1) stat_branches <= stat_branches + STAT_W'(1);
         if (mispred && stat_mispred != '1) stat_mispred <= stat_mispred + STAT_W'(1);
      end
   end

   // Address and instruction bits outside the index/opcode fields.
   logic unused_bits;
   assign unused_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0], if_inst[31:7],
                          ex_pc[31:IDX_W+2], ex_pc[1:0], ex_inst[31:7]};

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;
   localparam int FC = 3;
   localparam int SW = 4;
   localparam int SMAX = (1 << SW) - 1;

   localparam logic [31:0] BR   = 32'h0000_0063;
   localparam logic [31:0] JAL  = 32'h0000_006F;
   localparam logic [31:0] JALR = 32'h0000_0067;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, ex_valid, ex_pred, ex_taken, stall;
   logic [31:0]   if_pc, if_inst, ex_pc, ex_inst;
   logic          pred_taken, pc_sel, flush_ifid, flush_idex;
   logic [SW-1:0] stat_branches, stat_mispred;

   branch_predict_unit #(
      .ENTRIES(16), .IDX_W(4), .CNT_W(2), .FLUSH_CYCLES(FC), .STAT_W(SW)
   ) dut (
      .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst),
      .pred_taken(pred_taken), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_inst(ex_inst), .ex_pred(ex_pred), .ex_taken(ex_taken),
      .stall(stall), .pc_sel(pc_sel), .flush_ifid(flush_ifid),
      .flush_idex(flush_idex), .stat_branches(stat_branches),
      .stat_mispred(stat_mispred)
   );

   typedef struct {
      logic        r;
      logic [31:0] ipc, iin;
      logic        v;
      logic [31:0] epc, ein;
      logic        ep, et, st;
   } stim_t;

   int total = 0;
   int bad   = 0;

   // Reference model: counters as plain integers, flush hold as "cycles left".
   int mtab [16];
   int mleft, mbr, mmis;
   logic [4+2*SW-1:0] sbq [$];
   logic [4+2*SW-1:0] obs;
   assign obs = {pred_taken, pc_sel, flush_ifid, flush_idex, stat_branches, stat_mispred};

   function automatic bit m_redir();
      bit jmp, br;
      jmp = ex_valid && (ex_inst[6:0] == JAL[6:0] || ex_inst[6:0] == JALR[6:0]);
      br  = ex_valid && (ex_inst[6:0] == BR[6:0]);
      return jmp || (br && ex_pred != ex_taken);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) mtab[i] = 1;
         mleft = 0; mbr = 0; mmis = 0;
      end else begin
         if (m_redir()) mleft = FC - 1;
         else if (mleft > 0) mleft = mleft - 1;
         if (ex_valid && ex_inst[6:0] == BR[6:0]) begin
            if (ex_taken) mtab[ex_pc[5:2]] = (mtab[ex_pc[5:2]] == 3) ? 3 : mtab[ex_pc[5:2]] + 1;
            else          mtab[ex_pc[5:2]] = (mtab[ex_pc[5:2]] == 0) ? 0 : mtab[ex_pc[5:2]] - 1;
            mbr = (mbr == SMAX) ? SMAX : mbr + 1;
            if (ex_pred != ex_taken) mmis = (mmis == SMAX) ? SMAX : mmis + 1;
         end
      end
   end

   function automatic stim_t mk(logic r, logic [31:0] ipc, logic [31:0] iin, logic v,
                                logic [31:0] epc, logic [31:0] ein, logic ep, logic et, logic st);
      stim_t s;
      s.r = r; s.ipc = ipc; s.iin = iin; s.v = v; s.epc = epc; s.ein = ein;
      s.ep = ep; s.et = et; s.st = st;
      return s;
   endfunction

   function automatic stim_t lk(logic [31:0] ipc);
      return mk(1'b0, ipc, BR, 1'b0, 32'h0, NOP, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic stim_t rs();
      return mk(1'b1, 32'h0, NOP, 1'b0, 32'h0, NOP, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic stim_t idle();
      return mk(1'b0, 32'h0, NOP, 1'b0, 32'h0, NOP, 1'b0, 1'b0, 1'b0);
   endfunction

   // Drive one cycle of stimulus, then push the model's expectation.
   task automatic drive(input stim_t s);
      logic p, ps, fi, fe;
      @(negedge clk);
      rst = s.r; if_pc = s.ipc; if_inst = s.iin; ex_valid = s.v; ex_pc = s.epc;
      ex_inst = s.ein; ex_pred = s.ep; ex_taken = s.et; stall = s.st;
      #1;
      p  = (if_inst[6:0] == BR[6:0]) && (mtab[if_pc[5:2]] >= 2);
      ps = 1'b1; fi = 1'b0; fe = 1'b0;
      if (rst)             begin fi = 1'b1; fe = 1'b1; end
      else if (m_redir())  begin ps = 1'b0; fi = 1'b1; fe = 1'b1; end
      else if (mleft > 0)  begin fi = 1'b1; fe = 1'b1; end
      else if (stall)      fe = 1'b1;
      sbq.push_back({p, ps, fi, fe, SW'(mbr), SW'(mmis)});
      #1;
   endtask

   task automatic test_reset();
      stim_t q [$];
      logic [4+2*SW-1:0] e;
      q.push_back(mk(1'b1, 32'h40, BR, 1'b1, 32'h40, JAL, 1'b0, 1'b0, 1'b0));
      q.push_back(mk(1'b1, 32'h40, BR, 1'b1, 32'h40, JAL, 1'b0, 1'b0, 1'b0));
      q.push_back(idle());
      foreach (q[i]) begin
         drive(q[i]); e = sbq.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL reset row %0d: got %h want %h", i, obs, e); end
      end
      total++;
      if ({stat_branches, stat_mispred} !== '0) begin
         bad++; $display("FAIL reset_stats: got %h want 0", {stat_branches, stat_mispred});
      end
   endtask

   task automatic test_saturation();
      stim_t q [$];
      logic [4+2*SW-1:0] e;
      q.push_back(rs());
      q.push_back(lk(32'h40));
      repeat (4) q.push_back(mk(1'b0, 32'h40, BR, 1'b1, 32'h40, BR, 1'b1, 1'b1, 1'b0));
      q.push_back(lk(32'h40));
      repeat (2) q.push_back(mk(1'b0, 32'h40, BR, 1'b1, 32'h40, BR, 1'b0, 1'b0, 1'b0));
      q.push_back(lk(32'h40));
      foreach (q[i]) begin
         drive(q[i]); e = sbq.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL saturation row %0d: got %h want %h", i, obs, e); end
      end
      // 11 -> 10 -> 01 after two not-taken updates: weakly not-taken again
      total++;
      if (pred_taken !== 1'b0) begin bad++; $display("FAIL sat_final_pred: got %b want 0", pred_taken); end
   endtask

   task automatic test_mispredict();
      stim_t q [$];
      logic [4+2*SW-1:0] e;
      q.push_back(rs());
      q.push_back(mk(1'b0, 32'h0, NOP, 1'b1, 32'h100, BR, 1'b1, 1'b0, 1'b0));
      repeat (3) q.push_back(idle());
      foreach (q[i]) begin
         drive(q[i]); e = sbq.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL mispredict row %0d: got %h want %h", i, obs, e); end
      end
      total++;
      if (stat_mispred !== SW'(1) || stat_branches !== SW'(1)) begin
         bad++; $display("FAIL mispredict_stats: got %0d/%0d want 1/1", stat_branches, stat_mispred);
      end
   endtask

   task automatic test_jal_hold();
      stim_t q [$];
      logic [4+2*SW-1:0] e;
      q.push_back(rs());
      q.push_back(mk(1'b0, 32'h80, BR, 1'b1, 32'h80, JAL, 1'b0, 1'b0, 1'b0));
      repeat (3) q.push_back(lk(32'h80));
      q.push_back(mk(1'b0, 32'h80, BR, 1'b0, 32'h80, JAL, 1'b0, 1'b0, 1'b0));
      q.push_back(mk(1'b0, 32'h0, NOP, 1'b1, 32'h80, JAL, 1'b0, 1'b0, 1'b0));
      q.push_back(idle());
      q.push_back(mk(1'b0, 32'h0, NOP, 1'b1, 32'h84, JAL, 1'b0, 1'b0, 1'b0));
      repeat (3) q.push_back(idle());
      foreach (q[i]) begin
         drive(q[i]); e = sbq.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL jal_hold row %0d: got %h want %h", i, obs, e); end
      end
   endtask

   task automatic test_stall();
      stim_t q [$];
      logic [4+2*SW-1:0] e;
      q.push_back(rs());
      q.push_back(mk(1'b0, 32'h0, NOP, 1'b1, 32'h10, NOP, 1'b0, 1'b0, 1'b1));
      q.push_back(mk(1'b0, 32'h0, NOP, 1'b1, 32'h10, JALR, 1'b0, 1'b0, 1'b1));
      q.push_back(mk(1'b0, 32'h0, NOP, 1'b0, 32'h0, NOP, 1'b0, 1'b0, 1'b1));
      q.push_back(mk(1'b0, 32'h0, NOP, 1'b0, 32'h0, NOP, 1'b0, 1'b0, 1'b1));
      q.push_back(mk(1'b0, 32'h0, NOP, 1'b0, 32'h0, NOP, 1'b0, 1'b0, 1'b1));
      q.push_back(idle());
      foreach (q[i]) begin
         drive(q[i]); e = sbq.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL stall row %0d: got %h want %h", i, obs, e); end
      end
   endtask

   task automatic test_same_index();
      stim_t q [$];
      logic [4+2*SW-1:0] e;
      q.push_back(rs());
      q.push_back(mk(1'b0, 32'h44, BR, 1'b1, 32'h44, BR, 1'b0, 1'b1, 1'b0));
      q.push_back(lk(32'h44));
      foreach (q[i]) begin
         drive(q[i]); e = sbq.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL same_index row %0d: got %h want %h", i, obs, e); end
      end
   endtask

   task automatic test_stat_sat();
      stim_t q [$];
      logic [4+2*SW-1:0] e;
      q.push_back(rs());
      for (int k = 0; k < 17; k++)
         q.push_back(mk(1'b0, 32'h0, NOP, 1'b1, 32'(k * 4), BR, 1'(k & 1), 1'b0, 1'b0));
      q.push_back(idle());
      foreach (q[i]) begin
         drive(q[i]); e = sbq.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL stat_sat row %0d: got %h want %h", i, obs, e); end
      end
      total++;
      if (stat_branches !== 4'hF) begin bad++; $display("FAIL stat_branches_sat: got %0d want 15", stat_branches); end
   endtask

   task automatic test_reset_mid_hold();
      stim_t q [$];
      logic [4+2*SW-1:0] e;
      q.push_back(mk(1'b0, 32'h0, NOP, 1'b1, 32'h20, JAL, 1'b0, 1'b0, 1'b0));
      q.push_back(idle());
      q.push_back(rs());
      q.push_back(idle());
      for (int k = 0; k < 16; k++) begin
         q.push_back(mk(1'b0, 32'(k * 4), BR, 1'b1, 32'(k * 4), BR, 1'b1, 1'b1, 1'b0));
         q.push_back(lk(32'(k * 4)));
      end
      foreach (q[i]) begin
         drive(q[i]); e = sbq.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL reset_mid_hold row %0d: got %h want %h", i, obs, e); end
      end
   endtask

   initial begin
      rst = 1'b1; if_pc = '0; if_inst = NOP; ex_valid = 1'b0; ex_pc = '0;
      ex_inst = NOP; ex_pred = 1'b0; ex_taken = 1'b0; stall = 1'b0;
      @(posedge clk);
      test_reset();
      test_saturation();
      test_mispredict();
      test_jal_hold();
      test_stall();
      test_same_index();
      test_stat_sat();
      test_reset_mid_hold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Parametrised branch prediction and flush controller for the 5-stage RISC-V pipeline. It keeps a PC-indexed table of N-bit saturating counters and gives a taken/not-taken prediction at fetch. At execute it resolves conditional branches, JAL and JALR, updates the table, and drives pc select plus per-register flush controls. Flushes can be held for a programmable number of cycles. Saturating statistics counters are kept for performance debug.

Parameters:
ENTRIES, 16, number of predictor table entries; power of two, minimum 2.
IDX_W, 4, log2(ENTRIES); table index = pc[IDX_W+1:2].
CNT_W, 2, width of each saturating counter; minimum 1.
FLUSH_CYCLES, 1, cycles a redirect flush is held asserted; minimum 1.
STAT_W, 16, width of each statistics counter.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
if_pc  input  32  fetch-stage PC used for lookup.
if_inst  input  32  fetched instruction; lookup is qualified by opcode.
pred_taken  output  1  fetch prediction: 1 = redirect fetch to the branch target.
ex_valid  input  1  execute-stage instruction is valid (not a bubble).
ex_pc  input  32  execute-stage PC, used for table update.
ex_inst  input  32  execute-stage instruction.
ex_pred  input  1  prediction carried down the pipeline with the instruction.
ex_taken  input  1  branch outcome computed by the ALU.
stall  input  1  load-use stall request from hazard unit.
pc_sel  output  1  0 = load ALU/corrected target into PC; 1 = normal sequential or predicted path.
flush_ifid  output  1  clear the IF/ID register.
flush_idex  output  1  clear the ID/EX register.
stat_branches  output  STAT_W  resolved conditional branches.
stat_mispred  output  STAT_W  mispredicted conditional branches.

Behaviour:
- Opcodes: BRANCH = 1100011, JAL = 1101111, JALR = 1100111; all other opcodes are non-control.
- Lookup is combinational. pred_taken = MSB of table[if_pc[IDX_W+1:2]] when if_inst opcode is BRANCH; otherwise 0.
- Resolution is combinational and applies only when ex_valid = 1.
  - BRANCH mispredict (ex_pred != ex_taken): pc_sel=0, flush_ifid=1, flush_idex=1.
  - BRANCH correct: pc_sel=1, no flush from resolution.
  - JAL or JALR: pc_sel=0, flush_ifid=1, flush_idex=1. No table update, no stats update.
- Redirect start: a BRANCH mispredict, JAL or JALR with ex_valid=1 is a "redirect". Its first flush cycle is combinational.
- Flush hold FSM:
  - States IDLE and HOLD.
  - On a redirect while in IDLE with FLUSH_CYCLES > 1: go to HOLD and load hold_cnt = FLUSH_CYCLES-1.
  - In HOLD: flush_ifid=1 and flush_idex=1. hold_cnt decrements each cycle; return to IDLE when it reaches 1.
  - A new redirect while in HOLD reloads hold_cnt; the flush extends and does not stack.
  - pc_sel=0 only on the redirect cycle itself.
- Stall, with no redirect and not in HOLD: pc_sel=1, flush_ifid=0, flush_idex=1 (bubble into EX, hold IF/ID).
- Stall arriving together with a redirect, or during HOLD: the redirect/HOLD values win.
- Idle: with no redirect, no HOLD and no stall, all flush outputs are 0 and pc_sel=1.
- Table update (clocked): on a valid BRANCH, increment table[ex_pc index] when ex_taken=1, else decrement. The counter saturates at 2^CNT_W-1 and at 0.
- Same-cycle lookup and update of the same index: lookup returns the pre-update value (read-before-write).
- Stats (clocked): stat_branches increments on each valid BRANCH. stat_mispred increments on each mispredicted valid BRANCH. Both saturate at all-ones and never wrap.
- ex_valid=0: no update, no stats change, no redirect. Any HOLD still counts down.
- Reset values:
  - every table entry = 2^(CNT_W-1)-1 (weakly not-taken; 01 for CNT_W=2);
  - FSM = IDLE, hold_cnt = 0;
  - stats = 0.
- Reset mid-HOLD: rst wins, so flush outputs drop the cycle after rst is sampled. While rst is asserted, pc_sel=1 and flush_ifid=flush_idex=1.

Test Plan:
- Reset, then BRANCH at if_pc 0x40: pred_taken=0. Resolve ex_taken=1 three times at ex_pc 0x40: after the first update pred_taken=1; the counter saturates at 11 and stays 11 on a 4th taken update.
- Valid BRANCH with ex_pred=1, ex_taken=0: the same cycle gives pc_sel=0, flush_ifid=1, flush_idex=1; stat_mispred goes 0 -> 1 and stat_branches goes 0 -> 1.
- FLUSH_CYCLES=3, JAL resolved at cycle t: flushes are high in cycles t, t+1, t+2 and low at t+3; pc_sel=0 only at t; the table is unchanged.
- stall=1 with a non-control ex_inst: pc_sel=1, flush_ifid=0, flush_idex=1. stall=1 together with a JALR: pc_sel=0 and both flushes 1.
- Same-index lookup and update in one cycle (counter 01, ex_taken=1): pred_taken=0 that cycle and 1 in the next.
- STAT_W=4 with 17 valid BRANCHes: stat_branches holds at 15. Asserting rst during HOLD clears all state, and every table entry reads back 01.
